// File: rtl/ahb3lite_to_apb_bridge_if.sv
// Signal bundle between the AHB3-Lite interconnect, the bridge and the APB4 peripheral cluster.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface ahb3lite_to_apb_bridge_if #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned PADDR_SIZE = 8,
  parameter int unsigned PDATA_SIZE = 32
);
  // AHB3-Lite slave side
  logic                    HSEL;
  logic [HADDR_SIZE-1:0]   HADDR;
  logic [HDATA_SIZE-1:0]   HWDATA;
  logic [HDATA_SIZE-1:0]   HRDATA;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic [3:0]              HPROT;
  logic [1:0]              HTRANS;
  logic                    HMASTLOCK;
  logic                    HREADY;
  logic                    HREADYOUT;
  logic                    HRESP;

  // APB4 master side
  logic                    PSEL;
  logic                    PENABLE;
  logic [2:0]              PPROT;
  logic                    PWRITE;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP,
    output PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP,
    input  PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb3lite_to_apb_bridge.sv
// AHB3-Lite slave to APB4 master bridge, single clock domain.
// Each accepted AHB transfer becomes exactly one APB SETUP/ACCESS transfer.
module ahb3lite_to_apb_bridge #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned PADDR_SIZE = 8,
  parameter int unsigned PDATA_SIZE = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  ahb3lite_to_apb_bridge_if.slave bus
);

  localparam int unsigned STRB_W   = PDATA_SIZE / 8;
  localparam int unsigned LSB_W    = $clog2(STRB_W);
  localparam logic [2:0]  MAX_SIZE = 3'($clog2(HDATA_SIZE / 8));

  if (PDATA_SIZE != HDATA_SIZE) begin : g_width_check
    $error("ahb3lite_to_apb_bridge: PDATA_SIZE must equal HDATA_SIZE");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                  state_q, state_d;
  logic                    hreadyout_q, hreadyout_d;
  logic                    hresp_q, hresp_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q;
  logic [2:0]              pprot_q;
  logic [STRB_W-1:0]       pstrb_q;
  logic [PADDR_SIZE-1:0]   paddr_q;
  logic [PDATA_SIZE-1:0]   pwdata_q;
  logic [HDATA_SIZE-1:0]   hrdata_q;

  logic                    accept_c;
  logic                    size_err_c;
  logic                    load_c;
  int unsigned             nbytes_c;
  logic [STRB_W-1:0]       mask_c;
  logic [LSB_W-1:0]        off_c;
  logic [STRB_W-1:0]       strb_c;

  assign accept_c   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign size_err_c = bus.HSIZE > MAX_SIZE;

  // Byte-lane strobe: 2**HSIZE ones placed at the size-aligned byte offset
  always_comb begin
    nbytes_c = 32'd1 << bus.HSIZE;
    mask_c   = '0;
    off_c    = '0;
    strb_c   = '0;
    if (!size_err_c) begin
      mask_c = {STRB_W{1'b1}} >> (STRB_W - nbytes_c);
      off_c  = bus.HADDR[LSB_W-1:0] & ~LSB_W'(nbytes_c - 32'd1);
      if (bus.HWRITE) begin
        strb_c = STRB_W'(mask_c << off_c);
      end
    end
  end

  // Next-state logic; AHB/APB control outputs are decoded from the next state
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          load_c = 1'b1;
          if (size_err_c) begin
            state_d = ST_ERR1;
          end else if (bus.HWRITE) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_WDATA:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.PREADY) begin
          state_d = bus.PSLVERR ? ST_ERR1 : ST_IDLE;
        end
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase

    hreadyout_d = (state_d == ST_IDLE)  || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1)  || (state_d == ST_ERR2);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
    end
  end

  // APB request fields are only reloaded at accept, so they hold through SETUP/ACCESS
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      pstrb_q  <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (load_c) begin
        paddr_q  <= bus.HADDR[PADDR_SIZE-1:0];
        pwrite_q <= bus.HWRITE;
        pprot_q  <= {~bus.HPROT[0], 1'b1, bus.HPROT[1]};
        pstrb_q  <= strb_c;
      end
      if (state_q == ST_WDATA) begin
        pwdata_q <= PDATA_SIZE'(bus.HWDATA);
      end
      if ((state_q == ST_ACCESS) && bus.PREADY && !bus.PSLVERR && !pwrite_q) begin
        hrdata_q <= HDATA_SIZE'(bus.PRDATA);
      end
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PPROT     = pprot_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PWDATA    = pwdata_q;

  // Burst type, lock, cacheability and upper address bits have no APB counterpart
  logic unused_c;
  assign unused_c = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT[3:2], bus.HADDR[HADDR_SIZE-1:PADDR_SIZE]};

endmodule

// File: tb/tb_ahb3lite_to_apb_bridge.sv
// Self-checking bench for ahb3lite_to_apb_bridge: scenario tasks plus a queue of expected AHB responses.
module tb_ahb3lite_to_apb_bridge;

  localparam int unsigned TIMEOUT = 50;

  typedef struct packed {
    logic        is_read;
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  localparam logic [31:0] WR_ADDR [5] = '{32'h13, 32'h22, 32'h23, 32'h01, 32'h07};
  localparam logic [2:0]  WR_SIZE [5] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd2};

  logic clk = 1'b0;
  logic rst;
  int   tests_run;
  int   tests_failed;
  exp_t sb_q[$];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  ahb3lite_to_apb_bridge_if bus ();

  ahb3lite_to_apb_bridge dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.slave)
  );

  task automatic ahb_idle();
    bus.HSEL      = 1'b0;
    bus.HTRANS    = 2'b00;
    bus.HREADY    = 1'b1;
    bus.HADDR     = '0;
    bus.HWRITE    = 1'b0;
    bus.HSIZE     = 3'd2;
    bus.HPROT     = 4'b0000;
    bus.HBURST    = 3'b000;
    bus.HMASTLOCK = 1'b0;
  endtask

  task automatic ahb_addr(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [3:0] prot);
    bus.HSEL      = 1'b1;
    bus.HTRANS    = 2'b10;
    bus.HREADY    = 1'b1;
    bus.HADDR     = a;
    bus.HWRITE    = w;
    bus.HSIZE     = sz;
    bus.HPROT     = prot;
    bus.HBURST    = 3'b000;
    bus.HMASTLOCK = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ahb_idle();
    bus.HWDATA  = '0;
    bus.PRDATA  = '0;
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP, bus.PWRITE} !== 5'b00100) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 00100",
               {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP, bus.PWRITE});
    end
    tests_run++;
    if ({bus.HRDATA, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 0",
               {bus.HRDATA, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    exp_t e;
    int   waited;
    bus.PRDATA = 32'hCAFEF00D;
    bus.PREADY = 1'b1;
    ahb_addr(32'h04, 1'b0, 3'd2, 4'b0011);
    e = '{1'b1, 1'b0, 32'hCAFEF00D};
    sb_q.push_back(e);
    @(negedge clk);
    ahb_idle();
    tests_run++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b100) begin
      tests_failed++;
      $display("FAIL read_setup: got %b expected 100", {bus.PSEL, bus.PENABLE, bus.HREADYOUT});
    end
    tests_run++;
    if ({bus.PADDR, bus.PWRITE, bus.PSTRB, bus.PPROT} !== {8'h04, 1'b0, 4'b0000, 3'b011}) begin
      tests_failed++;
      $display("FAIL read_apb_fields: got %h expected %h",
               {bus.PADDR, bus.PWRITE, bus.PSTRB, bus.PPROT}, {8'h04, 1'b0, 4'b0000, 3'b011});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b110) begin
      tests_failed++;
      $display("FAIL read_access: got %b expected 110", {bus.PSEL, bus.PENABLE, bus.HREADYOUT});
    end
    @(negedge clk);
    waited = 0;
    while (bus.HREADYOUT !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    e = sb_q.pop_front();
    tests_run++;
    if (waited !== 0) begin
      tests_failed++;
      $display("FAIL read_latency: got %0d extra cycles expected 0", waited);
    end
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== {1'b1, e.resp, 1'b0}) begin
      tests_failed++;
      $display("FAIL read_resp: got %b expected %b", {bus.HREADYOUT, bus.HRESP, bus.PSEL}, {1'b1, e.resp, 1'b0});
    end
    tests_run++;
    if (bus.HRDATA !== e.rdata) begin
      tests_failed++;
      $display("FAIL read_data: got %h expected %h", bus.HRDATA, e.rdata);
    end
    last_rdata = e.rdata;
  endtask

  task automatic test_write_strobes();
    exp_t        e;
    int          waited;
    int unsigned off;
    int unsigned nb;
    logic [31:0] d;
    logic [3:0]  exp_strb;
    for (int i = 0; i < 5; i++) begin
      d  = (i == 0) ? 32'h5A000000 : $urandom;
      nb = 32'd1 << WR_SIZE[i];
      off = WR_ADDR[i] % 4;
      off = off - (off % nb);
      for (int b = 0; b < 4; b++) exp_strb[b] = (b >= off) && (b < off + nb);
      ahb_addr(WR_ADDR[i], 1'b1, WR_SIZE[i], 4'b0000);
      e = '{1'b0, 1'b0, 32'h0};
      sb_q.push_back(e);
      @(negedge clk);
      ahb_idle();
      bus.HWDATA = d;
      tests_run++;
      if ({bus.HREADYOUT, bus.PSEL} !== 2'b00) begin
        tests_failed++;
        $display("FAIL write_wdata[%0d]: got %b expected 00", i, {bus.HREADYOUT, bus.PSEL});
      end
      @(negedge clk);
      bus.HWDATA = ~d;
      tests_run++;
      if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PSTRB, bus.PWDATA, bus.PPROT} !==
          {2'b10, WR_ADDR[i][7:0], 1'b1, exp_strb, d, 3'b110}) begin
        tests_failed++;
        $display("FAIL write_setup[%0d]: got %h expected %h", i,
                 {bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PSTRB, bus.PWDATA, bus.PPROT},
                 {2'b10, WR_ADDR[i][7:0], 1'b1, exp_strb, d, 3'b110});
      end
      @(negedge clk);
      tests_run++;
      if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b110) begin
        tests_failed++;
        $display("FAIL write_access[%0d]: got %b expected 110", i, {bus.PSEL, bus.PENABLE, bus.HREADYOUT});
      end
      @(negedge clk);
      waited = 0;
      while (bus.HREADYOUT !== 1'b1 && waited < TIMEOUT) begin
        @(negedge clk);
        waited++;
      end
      e = sb_q.pop_front();
      tests_run++;
      if ({bus.HREADYOUT, bus.HRESP, bus.PSEL, 8'(waited)} !== {1'b1, e.resp, 1'b0, 8'd0}) begin
        tests_failed++;
        $display("FAIL write_done[%0d]: got ready/resp/psel %b wait %0d expected 1%b0 wait 0", i,
                 {bus.HREADYOUT, bus.HRESP, bus.PSEL}, waited, e.resp);
      end
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    int   waited;
    ahb_addr(32'h40, 1'b1, 3'd2, 4'b0010);
    e = '{1'b0, 1'b0, 32'h0};
    sb_q.push_back(e);
    @(negedge clk);
    ahb_idle();
    bus.HWDATA = 32'h12345678;
    @(negedge clk);
    bus.HWDATA = 32'h0;
    bus.PREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.PREADY = (i == 3);
      tests_run++;
      if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b110) begin
        tests_failed++;
        $display("FAIL wait_access[%0d]: got %b expected 110", i, {bus.PSEL, bus.PENABLE, bus.HREADYOUT});
      end
      tests_run++;
      if ({bus.PADDR, bus.PWRITE, bus.PSTRB, bus.PWDATA, bus.PPROT} !==
          {8'h40, 1'b1, 4'b1111, 32'h12345678, 3'b111}) begin
        tests_failed++;
        $display("FAIL wait_stable[%0d]: got %h expected %h", i,
                 {bus.PADDR, bus.PWRITE, bus.PSTRB, bus.PWDATA, bus.PPROT},
                 {8'h40, 1'b1, 4'b1111, 32'h12345678, 3'b111});
      end
    end
    @(negedge clk);
    waited = 0;
    while (bus.HREADYOUT !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    e = sb_q.pop_front();
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP, bus.PSEL, 8'(waited)} !== {1'b1, e.resp, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL wait_done: got ready/resp/psel %b wait %0d expected 1%b0 wait 0",
               {bus.HREADYOUT, bus.HRESP, bus.PSEL}, waited, e.resp);
    end
  endtask

  task automatic test_slave_error();
    exp_t e;
    int   waited;
    bus.PRDATA  = 32'hDEADBEEF;
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    ahb_addr(32'h08, 1'b0, 3'd2, 4'b0000);
    e = '{1'b0, 1'b1, 32'h0};
    sb_q.push_back(e);
    @(negedge clk);
    ahb_idle();
    bus.PSLVERR = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b110) begin
      tests_failed++;
      $display("FAIL slverr_access: got %b expected 110", {bus.PSEL, bus.PENABLE, bus.HREADYOUT});
    end
    @(negedge clk);
    bus.PSLVERR = 1'b0;
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== 3'b010) begin
      tests_failed++;
      $display("FAIL slverr_err1: got %b expected 010", {bus.HREADYOUT, bus.HRESP, bus.PSEL});
    end
    @(negedge clk);
    waited = 0;
    while (bus.HREADYOUT !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    e = sb_q.pop_front();
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP, 8'(waited)} !== {1'b1, e.resp, 8'd0}) begin
      tests_failed++;
      $display("FAIL slverr_err2: got ready/resp %b wait %0d expected 1%b wait 0",
               {bus.HREADYOUT, bus.HRESP}, waited, e.resp);
    end
    tests_run++;
    if (bus.HRDATA !== last_rdata) begin
      tests_failed++;
      $display("FAIL slverr_hrdata_kept: got %h expected %h", bus.HRDATA, last_rdata);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin
      tests_failed++;
      $display("FAIL slverr_okay_after: got %b expected 10", {bus.HREADYOUT, bus.HRESP});
    end
  endtask

  task automatic test_size_error();
    exp_t e;
    int   waited;
    ahb_addr(32'h10, 1'b0, 3'b011, 4'b0000);
    e = '{1'b0, 1'b1, 32'h0};
    sb_q.push_back(e);
    @(negedge clk);
    ahb_idle();
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== 3'b010) begin
      tests_failed++;
      $display("FAIL size_err1: got %b expected 010", {bus.HREADYOUT, bus.HRESP, bus.PSEL});
    end
    @(negedge clk);
    e = sb_q.pop_front();
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP, bus.PSEL} !== {1'b1, e.resp, 1'b0}) begin
      tests_failed++;
      $display("FAIL size_err2: got %b expected 1%b0", {bus.HREADYOUT, bus.HRESP, bus.PSEL}, e.resp);
    end
    // new transfer presented during the second error cycle
    bus.PRDATA = 32'h0BADF00D;
    bus.PREADY = 1'b1;
    ahb_addr(32'h0C, 1'b0, 3'd2, 4'b0000);
    e = '{1'b1, 1'b0, 32'h0BADF00D};
    sb_q.push_back(e);
    @(negedge clk);
    ahb_idle();
    tests_run++;
    if ({bus.PSEL, bus.PENABLE, bus.HRESP, bus.PADDR} !== {3'b100, 8'h0C}) begin
      tests_failed++;
      $display("FAIL err2_accept: got %h expected %h", {bus.PSEL, bus.PENABLE, bus.HRESP, bus.PADDR}, {3'b100, 8'h0C});
    end
    waited = 0;
    while (bus.HREADYOUT !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    e = sb_q.pop_front();
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA, 8'(waited)} !== {1'b1, e.resp, e.rdata, 8'd2}) begin
      tests_failed++;
      $display("FAIL err2_read_done: got data %h ready/resp %b wait %0d expected %h 1%b wait 2",
               bus.HRDATA, {bus.HREADYOUT, bus.HRESP}, waited, e.rdata, e.resp);
    end
    last_rdata = e.rdata;
  endtask

  task automatic test_no_select();
    for (int i = 0; i < 3; i++) begin
      ahb_addr(32'h50, 1'b1, 3'd2, 4'b0000);
      if (i == 0) bus.HSEL   = 1'b0;
      if (i == 1) bus.HTRANS = 2'b01;
      if (i == 2) bus.HREADY = 1'b0;
      @(negedge clk);
      ahb_idle();
      tests_run++;
      if ({bus.PSEL, bus.HREADYOUT, bus.HRESP} !== 3'b010) begin
        tests_failed++;
        $display("FAIL no_accept[%0d]: got %b expected 010", i, {bus.PSEL, bus.HREADYOUT, bus.HRESP});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_reset();
    exp_t e;
    int   waited;
    bus.PRDATA = 32'h11112222;
    bus.PREADY = 1'b1;
    ahb_addr(32'h20, 1'b0, 3'd2, 4'b0000);
    e = '{1'b1, 1'b0, 32'h11112222};
    sb_q.push_back(e);
    @(negedge clk);
    ahb_idle();
    @(negedge clk);
    @(negedge clk);
    waited = 0;
    while (bus.HREADYOUT !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    e = sb_q.pop_front();
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA, 8'(waited)} !== {1'b1, e.resp, e.rdata, 8'd0}) begin
      tests_failed++;
      $display("FAIL b2b_first_done: got data %h ready/resp %b wait %0d expected %h 1%b wait 0",
               bus.HRDATA, {bus.HREADYOUT, bus.HRESP}, waited, e.rdata, e.resp);
    end
    // second NONSEQ in the completion cycle; it is abandoned by reset below
    bus.PRDATA = 32'h33334444;
    ahb_addr(32'h24, 1'b0, 3'd2, 4'b0000);
    @(negedge clk);
    ahb_idle();
    bus.PREADY = 1'b0;
    tests_run++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.PADDR} !== {3'b100, 8'h24}) begin
      tests_failed++;
      $display("FAIL b2b_setup: got %h expected %h", {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.PADDR}, {3'b100, 8'h24});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
      tests_failed++;
      $display("FAIL b2b_access: got %b expected 11", {bus.PSEL, bus.PENABLE});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.PREADY = 1'b1;
    tests_run++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP, bus.PADDR, bus.HRDATA} !== {4'b0010, 8'h00, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid_access: got %h expected %h",
               {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP, bus.PADDR, bus.HRDATA}, {4'b0010, 8'h00, 32'h0});
    end
    bus.PRDATA = 32'h76543210;
    ahb_addr(32'h30, 1'b0, 3'd2, 4'b0000);
    e = '{1'b1, 1'b0, 32'h76543210};
    sb_q.push_back(e);
    @(negedge clk);
    ahb_idle();
    waited = 0;
    while (bus.HREADYOUT !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    e = sb_q.pop_front();
    tests_run++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA, 8'(waited)} !== {1'b1, e.resp, e.rdata, 8'd2}) begin
      tests_failed++;
      $display("FAIL post_reset_read: got data %h ready/resp %b wait %0d expected %h 1%b wait 2",
               bus.HRDATA, {bus.HREADYOUT, bus.HRESP}, waited, e.rdata, e.resp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_rdata   = 32'h0;
    test_reset();
    test_read();
    test_write_strobes();
    test_wait_states();
    test_slave_error();
    test_size_error();
    test_no_select();
    test_back_to_back_reset();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
